// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture unit: register map, control/status bit
// positions and the measurement FSM state encoding.
package pwm_capture_pkg;

   localparam logic [15:0] ADDR_CTRL   = 16'h0000;
   localparam logic [15:0] ADDR_DIV    = 16'h0002;
   localparam logic [15:0] ADDR_PERIOD = 16'h0004;
   localparam logic [15:0] ADDR_HIGH   = 16'h0006;
   localparam logic [15:0] ADDR_STATUS = 16'h0008;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_CONT = 1;
   localparam int CTRL_IE   = 2;
   localparam int CTRL_INV  = 3;
   localparam int CTRL_SRST = 7;

   // Only en/cont/ie/inv/srst are storage; bits 6:4 always read back 0.
   localparam logic [7:0] CTRL_WMASK = 8'h8F;

   localparam int ST_DONE = 0;
   localparam int ST_OVF  = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_HIGH = 2'd2,
      S_LOW  = 2'd3
   } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// 16-bit Wishbone slave bundle of the PWM capture register file.
interface pwm_capture_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [15:0] i_wb_adr;
   logic [15:0] i_wb_data;
   logic [15:0] o_wb_data;
   logic        o_wb_ack;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
      input  o_wb_data, o_wb_ack
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
      output o_wb_data, o_wb_ack
   );
endinterface

// File: rtl/pwm_cap_sync.sv
// Input synchronizer for the asynchronous PWM pin with optional inversion and
// single-cycle rise/fall detection pulses.
module pwm_cap_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pwm_i,
   input  logic inv_i,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   level_s;

   assign level_s = sync_q[SYNC_STAGES-1] ^ inv_i;
   assign rise_o  = level_s & ~prev_q;
   assign fall_o  = ~level_s & prev_q;

   // Synchronizer chain plus the previous-level register used for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
         prev_q <= level_s;
      end
   end
endmodule

// File: rtl/pwm_capture.sv
// PWM input-capture top: Wishbone register file, tick prescaler, measurement
// FSM and the o_DC/o_valid_DC duty-cycle stream.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic         i_wb_clk,
   input  logic         i_wb_rst,
   pwm_capture_if.slave wb,
   input  logic         i_pwm,
   output logic [15:0]  o_DC,
   output logic         o_valid_DC,
   output logic         o_int
);
   state_e      state_q, state_d;
   logic [15:0] ct_q, ct_d, presc_q, presc_d, div_act_q, div_act_d, hold_q, hold_d;
   logic [15:0] div_q, div_d, period_q, period_d, high_q, high_d, dc_q, dc_d;
   logic [7:0]  ctrl_q, ctrl_d;
   logic [1:0]  status_q, status_d;
   logic        valid_q, valid_d;
   logic        rise_s, fall_s, tick_s, wr_s, capture_s, ovf_set_s, oneshot_end_s;
   logic [15:0] rdata_s;

   pwm_cap_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (i_wb_clk),
      .rst    (i_wb_rst),
      .pwm_i  (i_pwm),
      .inv_i  (ctrl_q[CTRL_INV]),
      .rise_o (rise_s),
      .fall_o (fall_s)
   );

   assign wr_s   = wb.i_wb_cyc & wb.i_wb_stb & wb.i_wb_we;
   // div_act_q is the divisor in force; a new divisor is only picked up at a wrap.
   assign tick_s = (presc_q == div_act_q);

   // Measurement FSM: state, tick counter, prescaler and high-time hold.
   always_comb begin
      state_d       = state_q;
      ct_d          = ct_q;
      presc_d       = presc_q;
      div_act_d     = div_act_q;
      hold_d        = hold_q;
      capture_s     = 1'b0;
      ovf_set_s     = 1'b0;
      oneshot_end_s = 1'b0;
      if (ctrl_q[CTRL_SRST] || !ctrl_q[CTRL_EN]) begin
         state_d   = S_IDLE;
         ct_d      = 16'd0;
         presc_d   = 16'd0;
         div_act_d = div_q;
         if (ctrl_q[CTRL_SRST]) hold_d = 16'd0;
         else                   hold_d = hold_q;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_ARM;
            S_ARM: begin
               if (rise_s) begin
                  state_d   = S_HIGH;
                  ct_d      = 16'd1;
                  presc_d   = 16'd0;
                  div_act_d = div_q;
               end else begin
                  state_d = S_ARM;
               end
            end
            S_HIGH, S_LOW: begin
               if (tick_s) begin
                  presc_d   = 16'd0;
                  div_act_d = div_q;
               end else begin
                  presc_d   = presc_q + 16'd1;
                  div_act_d = div_act_q;
               end
               if (tick_s && (ct_q == 16'hFFFF)) begin
                  ovf_set_s = 1'b1;
                  state_d   = S_ARM;
                  ct_d      = 16'd0;
                  presc_d   = 16'd0;
                  div_act_d = div_q;
               end else if ((state_q == S_HIGH) && fall_s) begin
                  hold_d  = ct_q;
                  state_d = S_LOW;
                  ct_d    = ct_q + {15'd0, tick_s};
               end else if ((state_q == S_LOW) && rise_s) begin
                  capture_s = 1'b1;
                  ct_d      = 16'd1;
                  presc_d   = 16'd0;
                  div_act_d = div_q;
                  // One-shot drops en so IDLE stays put until software re-arms.
                  if (ctrl_q[CTRL_CONT]) begin
                     state_d = S_HIGH;
                  end else begin
                     state_d       = S_IDLE;
                     oneshot_end_s = 1'b1;
                  end
               end else begin
                  ct_d = ct_q + {15'd0, tick_s};
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Register file next state: host writes, capture results and sticky status.
   always_comb begin
      valid_d = capture_s;
      if (wr_s && (wb.i_wb_adr == ADDR_CTRL)) ctrl_d = wb.i_wb_data[7:0] & CTRL_WMASK;
      else if (oneshot_end_s)                 ctrl_d = ctrl_q & ~(8'd1 << CTRL_EN);
      else                                    ctrl_d = ctrl_q;
      if (wr_s && (wb.i_wb_adr == ADDR_DIV)) div_d = wb.i_wb_data;
      else                                   div_d = div_q;
      if (ctrl_q[CTRL_SRST]) begin
         status_d = 2'd0;
         period_d = 16'd0;
         high_d   = 16'd0;
         dc_d     = 16'd0;
      end else begin
         if (wr_s && (wb.i_wb_adr == ADDR_STATUS)) status_d = status_q & ~wb.i_wb_data[1:0];
         else                                      status_d = status_q;
         status_d[ST_DONE] = status_d[ST_DONE] | capture_s;
         status_d[ST_OVF]  = status_d[ST_OVF]  | ovf_set_s;
         if (capture_s) begin
            period_d = ct_q;
            high_d   = hold_q;
            dc_d     = hold_q;
         end else begin
            period_d = period_q;
            high_d   = high_q;
            dc_d     = dc_q;
         end
      end
   end

   // State and register storage.
   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         state_q   <= S_IDLE;
         ct_q      <= 16'd0;
         presc_q   <= 16'd0;
         div_act_q <= 16'd0;
         hold_q    <= 16'd0;
         ctrl_q    <= 8'd0;
         div_q     <= 16'd0;
         status_q  <= 2'd0;
         period_q  <= 16'd0;
         high_q    <= 16'd0;
         dc_q      <= 16'd0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ct_q      <= ct_d;
         presc_q   <= presc_d;
         div_act_q <= div_act_d;
         hold_q    <= hold_d;
         ctrl_q    <= ctrl_d;
         div_q     <= div_d;
         status_q  <= status_d;
         period_q  <= period_d;
         high_q    <= high_d;
         dc_q      <= dc_d;
         valid_q   <= valid_d;
      end
   end

   // Combinational read mux.
   always_comb begin
      rdata_s = 16'd0;
      case (wb.i_wb_adr)
         ADDR_CTRL:   rdata_s = {8'd0, ctrl_q};
         ADDR_DIV:    rdata_s = div_q;
         ADDR_PERIOD: rdata_s = period_q;
         ADDR_HIGH:   rdata_s = high_q;
         ADDR_STATUS: rdata_s = {14'd0, status_q};
         default:     rdata_s = 16'd0;
      endcase
   end

   assign wb.o_wb_data = rdata_s;
   assign wb.o_wb_ack  = wb.i_wb_stb;
   assign o_DC         = dc_q;
   assign o_valid_DC   = valid_q;
   assign o_int        = status_q[ST_DONE] & ctrl_q[CTRL_IE];
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: random PWM patterns measured against a
// model that works in whole prescaler units.
module tb_pwm_capture;
   import pwm_capture_pkg::*;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pwm = 1'b0;
   logic [15:0] dc;
   logic        valid_dc, irq;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc_cnt  = 0;
   int          pulse_dc[$];
   int          pulse_t[$];
   int          pulse_int[$];

   pwm_capture_if wb();

   pwm_capture #(.SYNC_STAGES(SYNC)) dut (
      .i_wb_clk   (clk),
      .i_wb_rst   (rst),
      .wb         (wb),
      .i_pwm      (pwm),
      .o_DC       (dc),
      .o_valid_DC (valid_dc),
      .o_int      (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Record every duty-cycle pulse with its value, cycle stamp and interrupt level.
   always @(negedge clk) begin
      if (valid_dc === 1'b1) begin
         pulse_dc.push_back(int'(dc));
         pulse_t.push_back(cyc_cnt);
         pulse_int.push_back(int'(irq));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wb_write(input logic [15:0] a, input logic [15:0] d);
      wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b1;
      wb.i_wb_adr = a;    wb.i_wb_data = d;
      @(posedge clk);
      #1;
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic [15:0] a, output logic [15:0] d);
      wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_adr = a;
      #1;
      d = wb.o_wb_data;
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
      tick(1);
   endtask

   // n full periods (h clocks high out of p), then a closing rising edge.
   task automatic pwm_periods(input int h, input int p, input int n);
      for (int i = 0; i < n; i++) begin
         pwm = 1'b1; tick(h);
         pwm = 1'b0; tick(p - h);
      end
      pwm = 1'b1;
      tick(SYNC + 4);
   endtask

   task automatic clear_pulses();
      pulse_dc.delete(); pulse_t.delete(); pulse_int.delete();
   endtask

   task automatic test_reset();
      logic [15:0] v;
      tick(3);
      n_checks++; if (dc !== 16'd0 || valid_dc !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: dc=%0h valid=%b int=%b want 0/0/0", dc, valid_dc, irq); end
      rst = 1'b0;
      tick(2);
      for (int a = 0; a <= 10; a += 2) begin
         wb_read(16'(a), v);
         n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL reset_reg_%0d: got %0h want 0", a, v); end
      end
      wb.i_wb_stb = 1'b1; #1;
      n_checks++; if (wb.o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL ack_high: got %b want 1", wb.o_wb_ack); end
      wb.i_wb_stb = 1'b0; #1;
      n_checks++; if (wb.o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL ack_low: got %b want 0", wb.o_wb_ack); end
      tick(1);
   endtask

   task automatic test_regs();
      logic [15:0] v;
      wb_write(ADDR_DIV, 16'hBEEF);
      wb_read(ADDR_DIV, v);
      n_checks++; if (v !== 16'hBEEF) begin n_fail++; $display("FAIL div_rw: got %0h want beef", v); end
      wb_write(ADDR_CTRL, 16'h00F4);
      wb_read(ADDR_CTRL, v);
      n_checks++; if (v !== 16'h0084) begin n_fail++; $display("FAIL ctrl_mask: got %0h want 84", v); end
      wb_write(ADDR_CTRL, 16'h0000);
      wb_write(ADDR_DIV, 16'h0000);
   endtask

   task automatic test_continuous();
      logic [15:0] v;
      int d, hu, lu, h, p;
      for (int it = 0; it < 5; it++) begin
         if (it == 0) begin
            d = 0; hu = 10; lu = 30;
         end else begin
            d = $urandom_range(3, 0); hu = $urandom_range(20, 1); lu = $urandom_range(20, 1);
         end
         h = (d + 1) * hu;
         p = h + (d + 1) * lu;
         wb_write(ADDR_CTRL, 16'h0000);
         pwm = 1'b0;
         wb_write(ADDR_DIV, 16'(d));
         tick(5);
         clear_pulses();
         wb_write(ADDR_CTRL, 16'h0003);
         tick(5);
         pwm_periods(h, p, 3);
         wb_write(ADDR_CTRL, 16'h0000);
         n_checks++; if (pulse_dc.size() != 3) begin n_fail++; $display("FAIL cont_pulses it%0d d=%0d: got %0d want 3", it, d, pulse_dc.size()); end
         for (int i = 0; i < pulse_dc.size(); i++) begin
            n_checks++; if (pulse_dc[i] != hu) begin n_fail++; $display("FAIL cont_dc it%0d #%0d: got %0d want %0d", it, i, pulse_dc[i], hu); end
         end
         for (int i = 1; i < pulse_t.size(); i++) begin
            n_checks++; if (pulse_t[i] - pulse_t[i-1] != p) begin n_fail++; $display("FAIL cont_spacing it%0d: got %0d want %0d", it, pulse_t[i] - pulse_t[i-1], p); end
         end
         wb_read(ADDR_PERIOD, v);
         n_checks++; if (v !== 16'(hu + lu)) begin n_fail++; $display("FAIL cont_period it%0d d=%0d: got %0d want %0d", it, d, v, hu + lu); end
         wb_read(ADDR_HIGH, v);
         n_checks++; if (v !== 16'(hu)) begin n_fail++; $display("FAIL cont_high it%0d d=%0d: got %0d want %0d", it, d, v, hu); end
      end
   endtask

   task automatic test_oneshot_irq();
      logic [15:0] v;
      wb_write(ADDR_CTRL, 16'h0000);
      pwm = 1'b0;
      wb_write(ADDR_STATUS, 16'h0003);
      wb_write(ADDR_DIV, 16'd3);
      tick(5);
      clear_pulses();
      wb_write(ADDR_CTRL, 16'h0005);
      tick(5);
      pwm_periods(100, 400, 3);
      n_checks++; if (pulse_dc.size() != 1) begin n_fail++; $display("FAIL oneshot_pulses: got %0d want 1", pulse_dc.size()); end
      if (pulse_dc.size() >= 1) begin
         n_checks++; if (pulse_dc[0] != 25) begin n_fail++; $display("FAIL oneshot_dc: got %0d want 25", pulse_dc[0]); end
         n_checks++; if (pulse_int[0] != 1) begin n_fail++; $display("FAIL oneshot_int_timing: got %0d want 1", pulse_int[0]); end
      end
      wb_read(ADDR_PERIOD, v);
      n_checks++; if (v !== 16'd100) begin n_fail++; $display("FAIL oneshot_period: got %0d want 100", v); end
      wb_read(ADDR_HIGH, v);
      n_checks++; if (v !== 16'd25) begin n_fail++; $display("FAIL oneshot_high: got %0d want 25", v); end
      wb_read(ADDR_STATUS, v);
      n_checks++; if (v !== 16'd1) begin n_fail++; $display("FAIL oneshot_status: got %0h want 1", v); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_int: got %b want 1", irq); end
      wb_write(ADDR_STATUS, 16'h0001);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL int_clear: got %b want 0", irq); end
      wb_read(ADDR_STATUS, v);
      n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL status_w1c: got %0h want 0", v); end
   endtask

   task automatic test_invert();
      logic [15:0] v;
      wb_write(ADDR_CTRL, 16'h0000);
      wb_write(ADDR_DIV, 16'd0);
      pwm = 1'b1;
      wb_write(ADDR_CTRL, 16'h0008);
      tick(5);
      clear_pulses();
      wb_write(ADDR_CTRL, 16'h000B);
      tick(5);
      pwm_periods(30, 100, 3);
      wb_write(ADDR_CTRL, 16'h0000);
      n_checks++; if (pulse_dc.size() != 2) begin n_fail++; $display("FAIL inv_pulses: got %0d want 2", pulse_dc.size()); end
      for (int i = 0; i < pulse_dc.size(); i++) begin
         n_checks++; if (pulse_dc[i] != 70) begin n_fail++; $display("FAIL inv_dc #%0d: got %0d want 70", i, pulse_dc[i]); end
      end
      wb_read(ADDR_PERIOD, v);
      n_checks++; if (v !== 16'd100) begin n_fail++; $display("FAIL inv_period: got %0d want 100", v); end
      wb_read(ADDR_HIGH, v);
      n_checks++; if (v !== 16'd70) begin n_fail++; $display("FAIL inv_high: got %0d want 70", v); end
   endtask

   task automatic test_overflow();
      logic [15:0] v;
      pwm = 1'b0;
      wb_write(ADDR_STATUS, 16'h0003);
      tick(5);
      clear_pulses();
      wb_write(ADDR_CTRL, 16'h0001);
      tick(5);
      pwm = 1'b1;
      tick(65600);
      n_checks++; if (pulse_dc.size() != 0) begin n_fail++; $display("FAIL ovf_no_capture: got %0d pulses want 0", pulse_dc.size()); end
      wb_read(ADDR_STATUS, v);
      n_checks++; if (v !== 16'd2) begin n_fail++; $display("FAIL ovf_status: got %0h want 2", v); end
      pwm = 1'b0;
      tick(10);
      pwm_periods(20, 50, 1);
      n_checks++; if (pulse_dc.size() != 1) begin n_fail++; $display("FAIL ovf_recover_pulses: got %0d want 1", pulse_dc.size()); end
      wb_read(ADDR_PERIOD, v);
      n_checks++; if (v !== 16'd50) begin n_fail++; $display("FAIL ovf_recover_period: got %0d want 50", v); end
      wb_read(ADDR_HIGH, v);
      n_checks++; if (v !== 16'd20) begin n_fail++; $display("FAIL ovf_recover_high: got %0d want 20", v); end
      wb_read(ADDR_STATUS, v);
      n_checks++; if (v !== 16'd3) begin n_fail++; $display("FAIL ovf_recover_status: got %0h want 3", v); end
   endtask

   task automatic test_abort();
      logic [15:0] v;
      wb_write(ADDR_CTRL, 16'h0000);
      pwm = 1'b0;
      tick(5);
      wb_write(ADDR_CTRL, 16'h0003);
      tick(5);
      pwm_periods(15, 35, 1);
      clear_pulses();
      tick(3);
      wb_write(ADDR_CTRL, 16'h0000);
      pwm = 1'b0; tick(10);
      pwm = 1'b1; tick(10);
      pwm = 1'b0; tick(10);
      n_checks++; if (pulse_dc.size() != 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d want 0", pulse_dc.size()); end
      wb_read(ADDR_PERIOD, v);
      n_checks++; if (v !== 16'd35) begin n_fail++; $display("FAIL abort_period_kept: got %0d want 35", v); end
      wb_read(ADDR_HIGH, v);
      n_checks++; if (v !== 16'd15) begin n_fail++; $display("FAIL abort_high_kept: got %0d want 15", v); end
      n_checks++; if (dc !== 16'd15) begin n_fail++; $display("FAIL abort_dc_kept: got %0d want 15", dc); end
      wb_write(ADDR_CTRL, 16'h0080);
      tick(2);
      wb_write(ADDR_CTRL, 16'h0000);
      wb_read(ADDR_PERIOD, v);
      n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL srst_period: got %0d want 0", v); end
      wb_read(ADDR_HIGH, v);
      n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL srst_high: got %0d want 0", v); end
      wb_read(ADDR_STATUS, v);
      n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL srst_status: got %0h want 0", v); end
      n_checks++; if (dc !== 16'd0) begin n_fail++; $display("FAIL srst_dc: got %0d want 0", dc); end
   endtask

   task automatic test_race();
      logic [15:0] v;
      pwm = 1'b0;
      tick(5);
      clear_pulses();
      wb_write(ADDR_CTRL, 16'h0003);
      tick(5);
      pwm_periods(10, 30, 1);
      tick(10 - (SYNC + 4));
      pwm = 1'b0;
      tick(20);
      // The capture edge lands SYNC+1 clocks after this rise; the W1C shares that edge.
      pwm = 1'b1;
      tick(SYNC);
      wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b1;
      wb.i_wb_adr = ADDR_STATUS; wb.i_wb_data = 16'h0001;
      @(posedge clk);
      #1;
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
      tick(2);
      n_checks++; if (pulse_dc.size() != 2) begin n_fail++; $display("FAIL race_pulses: got %0d want 2", pulse_dc.size()); end
      wb_read(ADDR_STATUS, v);
      n_checks++; if (v !== 16'd1) begin n_fail++; $display("FAIL race_done_set_wins: got %0h want 1", v); end
      wb_read(ADDR_PERIOD, v);
      n_checks++; if (v !== 16'd30) begin n_fail++; $display("FAIL race_period: got %0d want 30", v); end
      wb_write(ADDR_CTRL, 16'h0000);
      wb_write(ADDR_STATUS, 16'h0001);
      wb_read(ADDR_STATUS, v);
      n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL race_plain_w1c: got %0h want 0", v); end
   endtask

   initial begin
      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
      wb.i_wb_adr = 16'd0; wb.i_wb_data = 16'd0;
      #1;
      test_reset();
      test_regs();
      test_continuous();
      test_oneshot_irq();
      test_invert();
      test_overflow();
      test_abort();
      test_race();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM input-capture unit: receiver counterpart of the PWM generator. Measures period and high time of an external PWM signal in prescaled clock ticks and exposes them through a 16-bit Wishbone slave register file. Also drives a duty-cycle stream (`o_DC`/`o_valid_DC`) shaped to feed a generator's external duty-cycle input directly, for PWM-to-PWM loop-back and servo-style relaying.

## Interface
- `SYNC_STAGES`, 2: input synchronizer depth; minimum 2.
- `i_wb_clk`  in  1  sole clock; all logic is in this domain.
- `i_wb_rst`  in  1  asynchronous, active-high reset.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`  in  1  Wishbone strobes. A write occurs when `cyc&stb&we`.
- `i_wb_adr`  in  16  byte address.
- `i_wb_data`  in  16  write data.
- `o_wb_data`  out  16  combinational read mux; 0 for unmapped addresses.
- `o_wb_ack`  out  1  equals `i_wb_stb`, giving zero-wait-state access.
- `i_pwm`  in  1  asynchronous PWM input.
- `o_DC`  out  16  last captured high time.
- `o_valid_DC`  out  1  one-cycle pulse when `o_DC` updates.
- `o_int`  out  1  level interrupt: `status.done & ctrl.ie`.

## Operation
- Register map (address: name):
  - 0: `ctrl`, RW, 8 bits. Bit 0 `en`; bit 1 `cont` (1 = continuous, 0 = one-shot); bit 2 `ie`; bit 3 `inv` (invert input after synchronizer); bit 7 `srst`. Bits 6:4 read 0.
  - 2: `divisor`, RW.
  - 4: `period`, RO.
  - 6: `high`, RO.
  - 8: `status`, W1C. Bit 0 `done`; bit 1 `ovf`.
- Tick generation: a prescaler counts 0..`divisor` and ticks when it equals `divisor`. With `divisor=0`, every clock is a tick.
- States:
  - IDLE: entered on reset, `en=0`, `srst`, or completion of a one-shot capture. Leaves for ARM when `en=1`.
  - ARM: waits for a detected rising edge, then goes to HIGH with `ct<=1` and prescaler cleared.
  - HIGH: `ct` increments on each tick. On a falling edge, latch `hold<=ct` and go to LOW.
  - LOW: `ct` increments on each tick. On a rising edge:
    - Capture: `period<=ct`, `high<=hold`, `o_DC<=hold`, pulse `o_valid_DC`, set `done`.
    - Then: if `cont`, go to HIGH with `ct<=1` and prescaler cleared; otherwise go to IDLE.
- Overflow: a tick in HIGH or LOW with `ct=16'hFFFF` sets `ovf`, discards the measurement and returns to ARM. A stuck input therefore never produces a capture.
- Clearing `en` mid-measurement: go to IDLE and clear `ct`/prescaler. Captured registers and status are retained.
- `srst` (held while set): forces IDLE and clears `ct`, prescaler, `hold`, `period`, `high`, `o_DC`, `status`.
- Writing `divisor` mid-measurement takes effect at the next prescaler wrap. The in-progress result is not corrected.
- Arithmetic: all counts are unsigned 16-bit. Units are (`divisor`+1) clocks. Results are truncated with an error of up to -1 unit.

## Timing
- Reset values: all registers 0, state IDLE. `o_wb_data` follows the address mux; all other outputs are 0.
- Edge latency: an `i_pwm` transition is seen as a detected edge `SYNC_STAGES+1` clocks later (synchronizer plus edge register).
- With `divisor=0`, a high time of H clocks and a period of P clocks yield `high=H` and `period=P` exactly, for H ≥ 1 and P ≥ 2.
- Capture timing: `period`, `high`, `o_DC` and `done` update on the clock following the rising-edge detect cycle. `o_valid_DC` is high for exactly that one cycle. `o_int` rises the same cycle as `done`.
- Simultaneous events:
  - A W1C of `done` in the same cycle as a new capture leaves `done=1` (set wins).
  - `srst` beats everything.
  - `en=0` beats a same-cycle edge.
- Register writes land on the clock after the write cycle. Reads are combinational.

## Structure
- Shared package/header `pwm_capture_pkg` holds:
  - register addresses (0/2/4/6/8);
  - `ctrl` and `status` bit indices;
  - 2-bit state encoding: IDLE=0, ARM=1, HIGH=2, LOW=3.
- Sub-module `pwm_cap_sync`: `SYNC_STAGES` flop chain, `inv` XOR, previous-value register, and `rise`/`fall` pulses.
- The top level holds the register file, prescaler, FSM and capture registers.
- Use a clock enable only; no derived clocks.

## Test plan
- Basic continuous capture:
  - Stimulus: `divisor=0`, `ctrl=0x03`, `i_pwm` with 10 clocks high and 40-clock period.
  - Response: `period=40`, `high=10`, one `o_valid_DC` pulse with `o_DC=10` every 40 clocks.
- Prescaled, one-shot, interrupt:
  - Stimulus: `divisor=3`, `ctrl=0x05`, 100 high / 400 period.
  - Response: `high=25`, `period=100`. `done=1` and `o_int=1` after the first period, then IDLE with no further pulses. Writing `status=1` drops `o_int`.
- Inverted input:
  - Stimulus: `inv=1`, 30 high / 100 period.
  - Response: `high=70`, `period=100`.
- Overflow:
  - Stimulus: `i_pwm` held at 1 for over 65536 ticks after a rise.
  - Response: `ovf=1`, no capture, state ARM. A normal PWM afterwards captures correctly.
- Abort paths:
  - Clear `en` in the HIGH state: no `o_valid_DC`, previous captures retained.
  - Pulse `srst`: all captures and status read 0.
- Race:
  - Stimulus: W1C of `done` issued on the same cycle as a capture update.
  - Response: `done` reads 1 afterwards.
